// File: rtl/pa_divider_seq.sv
// Multi-cycle restoring divider, one quotient bit per cycle, unsigned or signed
// (truncating toward zero) per operation, with divide-by-zero and MIN/-1 overflow flags.
module pa_divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_dbz,
  output logic             o_ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t           state;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  logic             in_dvd_neg;
  logic             in_dvs_neg;
  logic [WIDTH-1:0] in_dvd_mag;
  logic [WIDTH-1:0] in_dvs_mag;
  logic [WIDTH-1:0] min_val;
  logic             div_zero;
  logic             sgn_ovf;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  assign min_val    = {1'b1, {(WIDTH-1){1'b0}}};
  assign in_dvd_neg = i_signed & i_dividend[WIDTH-1];
  assign in_dvs_neg = i_signed & i_divisor[WIDTH-1];
  assign in_dvd_mag = in_dvd_neg ? -i_dividend : i_dividend;
  assign in_dvs_mag = in_dvs_neg ? -i_divisor : i_divisor;
  assign div_zero   = (i_divisor == '0);
  assign sgn_ovf    = i_signed && (i_dividend == min_val) && (i_divisor == '1);

  // dvd_mag doubles as the quotient: dividend bits leave at the MSB while quotient bits enter at the LSB
  assign shifted = {rem[WIDTH-1:0], dvd_mag[WIDTH-1]};
  assign trial   = {rem, dvd_mag[WIDTH-1]} - {2'b00, dvs_mag};

  assign o_ready = (state == IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dvd_mag     <= '0;
      dvs_mag     <= '0;
      rem         <= '0;
      cnt         <= '0;
      o_valid     <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_dbz       <= 1'b0;
      o_ovf       <= 1'b0;
    end else if (i_flush) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_dbz   <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            q_neg   <= in_dvd_neg ^ in_dvs_neg;
            r_neg   <= in_dvd_neg;
            dvd_mag <= in_dvd_mag;
            dvs_mag <= in_dvs_mag;
            rem     <= '0;
            cnt     <= CW'(WIDTH - 1);
            // Special results are loaded now and published one cycle later from DONE
            if (div_zero) begin
              o_quotient  <= '1;
              o_remainder <= i_dividend;
              o_dbz       <= 1'b1;
              o_ovf       <= 1'b0;
              state       <= DONE;
            end else if (sgn_ovf) begin
              o_quotient  <= min_val;
              o_remainder <= '0;
              o_dbz       <= 1'b0;
              o_ovf       <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem     <= trial[WIDTH+1] ? shifted : trial[WIDTH:0];
          dvd_mag <= {dvd_mag[WIDTH-2:0], ~trial[WIDTH+1]};
          cnt     <= cnt - 1'b1;
          if (cnt == '0) state <= FIXUP;
        end
        FIXUP: begin
          o_quotient  <= q_neg ? -dvd_mag : dvd_mag;
          o_remainder <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          o_dbz       <= 1'b0;
          o_ovf       <= 1'b0;
          o_valid     <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (!o_valid) begin
            o_valid <= 1'b1;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pa_divider_seq.md
Name: pa_divider_seq

Overview:
- Parametrised multi-cycle restoring divider: one quotient bit per cycle, WIDTH-bit operands.
- Supports unsigned and signed (two's-complement, truncating toward zero) modes, selected per operation.
- Valid/ready handshake on input and output; divide-by-zero and signed-overflow flags.
- Replaces the fixed single-mode divider; sits between the datapath issue stage and the writeback/result buffer.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits (>= 4).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_flush  in  1  synchronous abort; discards any operation in flight.
- i_valid  in  1  operands valid.
- o_ready  out  1  divider accepts operands this cycle.
- i_signed  in  1  1 = signed operation, 0 = unsigned; sampled at accept.
- i_dividend  in  WIDTH  dividend.
- i_divisor  in  WIDTH  divisor.
- o_valid  out  1  result valid; held until accepted.
- i_ready  in  1  downstream accepts result.
- o_quotient  out  WIDTH  quotient.
- o_remainder  out  WIDTH  remainder.
- o_dbz  out  1  divisor was zero; qualified by o_valid.
- o_ovf  out  1  signed overflow (MIN / -1); qualified by o_valid.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_valid=0, o_quotient=0, o_remainder=0, o_dbz=0, o_ovf=0. o_ready=1 once reset deasserts. Internal registers cleared.
- States: IDLE, CALC, FIXUP, DONE.
- o_ready = (state==IDLE). No accept while busy or holding a result.
- Accept: i_valid && o_ready at rising edge T. Latch i_signed, sign of dividend, sign of divisor, |dividend|, |divisor| (magnitudes only in signed mode; raw values otherwise).
- Divisor zero at accept:
  - Next state is DONE.
  - Quotient = all ones; remainder = original dividend (unsigned or signed).
  - o_dbz=1, o_ovf=0.
  - o_valid high after edge T+1.
- Signed, dividend = MIN, divisor = -1 at accept:
  - Next state is DONE.
  - Quotient = MIN (1 followed by WIDTH-1 zeros); remainder = 0.
  - o_ovf=1, o_dbz=0.
  - o_valid high after edge T+1.
- Otherwise, next state is CALC with iteration counter = WIDTH-1.
  - Partial remainder register is WIDTH+1 bits, cleared at accept.
- CALC, each edge:
  - Shift the next dividend magnitude bit, MSB first, into the partial remainder.
  - Trial subtract the divisor magnitude. If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - Counter decrements; at counter=0 go to FIXUP. Exactly WIDTH CALC edges (T+1..T+WIDTH).
- FIXUP, edge T+WIDTH+1:
  - Signed mode: negate quotient if dividend sign xor divisor sign; negate remainder if dividend sign (remainder takes sign of dividend).
  - Unsigned mode: pass through.
  - Register outputs, set o_valid=1, o_dbz=0, o_ovf=0, go to DONE.
  - Normal latency: o_valid visible in the cycle after edge T+WIDTH+1.
- DONE: outputs and flags stable while o_valid && !i_ready. On o_valid && i_ready at an edge: o_valid<=0, go to IDLE. No new accept until the following cycle (no overlap).
- i_flush=1 at an edge, any state: go to IDLE, o_valid<=0, flags<=0. Outputs retain their last values. Flush has priority over accept and result handoff.
- Output data and flags are don't-care when o_valid=0. Bench checks only when o_valid=1.
- Operand inputs are ignored outside the accept edge; changes during CALC have no effect.
- Reset mid-operation: immediate return to reset values; the operation is lost.

Test Plan:
- WIDTH=8, unsigned 100/7 -> o_quotient=14, o_remainder=2, dbz=ovf=0; o_valid first seen 10 cycles after accept edge; o_ready low throughout.
- WIDTH=8, signed -100/7 (0x9C/0x07) -> q=0xF2 (-14), r=0xFE (-2). Signed 100/-7 -> q=0xF2, r=0x02. Unsigned 0x9C/0x07 -> q=22, r=2.
- WIDTH=8: signed 0x80/0xFF -> q=0x80, r=0x00, o_ovf=1. Unsigned 0x55/0x00 -> q=0xFF, r=0x55, o_dbz=1. Both with o_valid 2 cycles after accept.
- Backpressure: 255/16 unsigned, hold i_ready=0 for 5 cycles after o_valid -> q=15, r=15 stable, o_ready=0. Raise i_ready -> o_valid drops next edge, o_ready=1 the cycle after.
- Flush/reset: assert i_flush 3 cycles into CALC -> IDLE next edge, o_valid never asserts. Repeat with async i_rst_n low mid-CALC -> all outputs 0 immediately. A following 9/3 -> q=3, r=0 correct.
- Random: 10k operations per mode at WIDTH=8 and WIDTH=32 with random i_valid/i_ready gaps -> match reference model bit-exact, including dbz/ovf cases.
